// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, glitch-rejecting start detect,
// framing/overrun checks and a valid/ready holding register. Optional parity via UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [15:0] TMR_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] TMR_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  BIT_LAST      = 4'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_param: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   rxd_meta_q, rxd_s_q;
  logic [15:0]            tmr_q, tmr_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   perr_hit;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic parity_err_q, parity_err_d;
  assign perr_hit   = perr_q;
  assign parity_err = parity_err_q;
`else
  assign perr_hit   = 1'b0;
  assign parity_err = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q && !rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
`ifdef UART_RX_PARITY_EN
        perr_d = 1'b0;
`endif
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (tmr_q == TMR_HALF_LAST) begin
          tmr_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tmr_q == TMR_BIT_LAST) begin
          tmr_d     = '0;
          shift_d   = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tmr_q == TMR_BIT_LAST) begin
          tmr_d   = '0;
          perr_d  = (^{shift_q, rxd_s_q}) ^ 1'(PARITY_ODD);
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tmr_q == TMR_BIT_LAST) begin
          tmr_d = '0;
          if (!rxd_s_q) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end else begin
            state_d = S_IDLE;
            if (perr_hit) begin
`ifdef UART_RX_PARITY_EN
              parity_err_d = 1'b1;
`endif
            end else if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      S_BREAK: begin
        // A line held low must go high before another start bit can be seen.
        tmr_d = '0;
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd;
      rxd_s_q     <= rxd_meta_q;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus random frames scored
// against a frame-level model (expected words and error counts). Honors UART_RX_PARITY_EN.
module tb_uart_rx_param;

  localparam int CPB     = 16;
  localparam int DB      = 8;
  localparam bit PAR_ODD = 1'b0;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          rxd;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, parity_err, overrun, busy;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(PAR_ODD)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Output observation, taken mid-cycle: pulse-high cycle counts and transferred words.
  int            fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, vh_cnt = 0;
  logic [DB-1:0] got_q[$];

  always @(negedge clk) begin
    if (n_rst) begin
      fe_cnt += int'(frame_err);
      pe_cnt += int'(parity_err);
      ov_cnt += int'(overrun);
      vh_cnt += int'(rx_valid);
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    tick(CPB);
  endtask

  // Drives one frame LSB first. abort_bit >= 0 stops halfway through that data bit.
  task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input logic stop,
                            input int abort_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) begin
      if (i == abort_bit) begin
        rxd = d[i];
        tick(CPB / 2);
        return;
      end
      drive_bit(d[i]);
    end
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PAR_ODD ^ bad_par);
`endif
    drive_bit(stop);
  endtask

  int fe0, pe0, ov0, vh0, gq0;

  task automatic snap();
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; vh0 = vh_cnt; gq0 = got_q.size();
  endtask

  initial begin
    logic [DB-1:0] exp_q[$];
    int            exp_fe, exp_pe;
    int            bound;

    n_rst = 1'b1; rxd = 1'b1; rx_ready = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_errors", {29'h0, frame_err, parity_err, overrun}, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick(3);
    n_rst = 1'b1;
    tick(4);

    // Clean frame with consumer ready: one-cycle valid, correct word, no flags.
    snap();
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    tick(4);
    check("a5_valid_cycles", 32'(vh_cnt - vh0), 32'd1);
    check("a5_words", 32'(got_q.size() - gq0), 32'd1);
    check("a5_data", 32'(got_q[$]), 32'hA5);
    check("a5_no_err", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 32'd0);

    // Short low glitch: start detected, rejected at mid-bit.
    snap();
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    check("glitch_busy_seen", 32'(busy), 32'd1);
    tick(20);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(vh_cnt - vh0), 32'd0);
    check("glitch_no_err", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 32'd0);

    // Stop bit low then line held low: one frame error, receiver parked until high.
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    rxd = 1'b0;
    tick(40);
    check("brk_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("brk_busy_held", 32'(busy), 32'd1);
    check("brk_no_valid", 32'(vh_cnt - vh0), 32'd0);
    rxd = 1'b1;
    tick(6);
    check("brk_released", 32'(busy), 32'd0);

    // Consumer stalled: second frame overruns, first word kept.
    snap();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, -1);
    send_frame(8'h22, 1'b0, 1'b1, -1);
    tick(4);
    check("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_clear", 32'(rx_valid), 32'd0);
    check("ovr_data_after", 32'(rx_data), 32'h11);
    check("ovr_transferred", 32'(got_q[$]), 32'h11);
    tick(4);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b1, -1);
    tick(4);
    check("par_bad_err", 32'(pe_cnt - pe0), 32'd1);
    check("par_bad_no_valid", 32'(vh_cnt - vh0), 32'd0);
    snap();
    send_frame(8'h07, 1'b0, 1'b1, -1);
    tick(4);
    check("par_good_err", 32'(pe_cnt - pe0), 32'd0);
    check("par_good_data", 32'(got_q[$]), 32'h07);
`endif

    // Reset mid-frame with a full holding register, then a clean frame.
    rx_ready = 1'b0;
    send_frame(8'h96, 1'b0, 1'b1, -1);
    tick(4);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    send_frame(8'hFF, 1'b0, 1'b1, 4);
    check("pre_rst_busy", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_flags", {29'h0, frame_err, parity_err, overrun}, 32'h0);
    rxd = 1'b1;
    tick(3);
    n_rst = 1'b1;
    tick(3);
    rx_ready = 1'b1;
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    tick(4);
    check("post_rst_words", 32'(got_q.size() - gq0), 32'd1);
    check("post_rst_data", 32'(got_q[$]), 32'h5A);
    check("post_rst_no_err", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 32'd0);

    // Random frames against the frame-level model.
    snap();
    exp_fe = 0;
    exp_pe = 0;
    for (int n = 0; n < 30; n++) begin
      logic [DB-1:0] d;
      bit            stop_bad, par_bad;
      d        = DB'($urandom);
      stop_bad = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
      par_bad  = ($urandom_range(0, 4) == 0);
`else
      par_bad  = 1'b0;
`endif
      send_frame(d, par_bad, !stop_bad, -1);
      rxd = 1'b1;
      tick(4 + $urandom_range(0, 12));
      if (stop_bad) exp_fe++;
      else if (par_bad) exp_pe++;
      else exp_q.push_back(d);
    end
    bound = 0;
    while (busy && bound < 100) begin
      tick(1);
      bound++;
    end
    check("rnd_settled", 32'(busy), 32'd0);
    check("rnd_frame_errs", 32'(fe_cnt - fe0), 32'(exp_fe));
    check("rnd_parity_errs", 32'(pe_cnt - pe0), 32'(exp_pe));
    check("rnd_overruns", 32'(ov_cnt - ov0), 32'd0);
    check("rnd_word_count", 32'(got_q.size() - gq0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (gq0 + i < got_q.size()) check($sformatf("rnd_word_%0d", i), 32'(got_q[gq0 + i]), 32'(exp_q[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the successor to the fixed 8N1 receiver. It adds a configurable bit period and data width, a 2-flop input synchroniser, and start-bit glitch rejection. It also adds stop-bit framing check, optional parity check, and a valid/ready output handshake with overrun detection. It sits between the board-level `rxd` pin and the command/byte consumer logic in the same `clk` domain.

## Interface
Parameters:
- `CLKS_PER_BIT`, 5208, clk cycles per bit (50 MHz / 9600 baud); legal 4..65535.
- `DATA_BITS`, 8, data bits per frame, LSB first; legal 5..9.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity. Used only when `UART_RX_PARITY_EN` is defined.

Ports:
- `clk` in 1: system clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `rxd` in 1: serial input, asynchronous, idle high.
- `rx_data` out DATA_BITS: received word in the holding register.
- `rx_valid` out 1: holding register is full.
- `rx_ready` in 1: consumer accepts the word; a transfer occurs when `rx_valid && rx_ready`.
- `frame_err` out 1: 1-cycle pulse, stop bit sampled low.
- `parity_err` out 1: 1-cycle pulse, parity mismatch.
- `overrun` out 1: 1-cycle pulse, completed frame dropped because the holding register is full.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Synchroniser: `rxd` passes through two flops, both reset to 1. All logic below uses the synchronised `rxd_s`.
- Timer: 16-bit `tmr`. It clears to 0 on every state entry and increments each clk otherwise.
- HALF = CLKS_PER_BIT/2, using integer division.
- Shift register: DATA_BITS wide. It shifts right and loads new bits at the MSB, so the first received bit ends up at bit 0.
- States:
  - IDLE: `tmr` is held at 0. When `rxd_s==0`, go to START.
  - START: at `tmr==HALF-1`, sample `rxd_s`. If 1, treat as a glitch and go to IDLE with no flag. If 0, go to DATA with bit index 0.
  - DATA: at `tmr==CLKS_PER_BIT-1`, sample `rxd_s` into the shift register and increment the bit index. After bit DATA_BITS-1, go to PARITY if parity is enabled, else to STOP.
  - PARITY: at `tmr==CLKS_PER_BIT-1`, compute `perr = ^{data, rxd_s} ^ PARITY_ODD`, then go to STOP.
  - STOP: at `tmr==CLKS_PER_BIT-1`, sample `rxd_s`.
    - If 0: pulse `frame_err`, discard the word, go to BREAK.
    - If 1 and `perr`: pulse `parity_err`, discard the word, go to IDLE.
    - Otherwise the frame is good: deliver it and go to IDLE.
  - BREAK: wait until `rxd_s==1`, then go to IDLE. This prevents a held-low line from retriggering START.
- Delivery of a good frame, decided on the cycle the stop bit is sampled:
  - `rx_valid==0`: load `rx_data`; set `rx_valid`.
  - `rx_valid==1 && rx_ready==1`: the old word transfers, the new word loads, and `rx_valid` stays 1.
  - `rx_valid==1 && rx_ready==0`: pulse `overrun`; keep the old word; drop the new one.
- Outside delivery, `rx_valid && rx_ready` clears `rx_valid` on the next cycle. `rx_data` holds its value after the transfer.
- At most one error pulse per frame. `frame_err` takes priority over `parity_err`.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0. State is IDLE, `tmr`=0, and both synchroniser flops are 1.
- Reset asserted mid-frame aborts immediately. The partial word is lost.
- Latencies:
  - Pin falling edge to START entry: 3 clk (2 sync flops + state register).
  - Start-bit sample: HALF clk after START entry.
  - Each later sample (data, parity, stop): CLKS_PER_BIT clk apart, at mid-bit.
- `rx_valid`, the error pulses and `overrun` are registered. They assert on the clk after the stop-bit sample.
- IDLE is re-entered at mid-stop-bit. A start edge arriving anywhere from there on is accepted, which tolerates a sender running fast by up to half a bit.
- Timer compare values are constants derived from parameters. No divider hardware.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state exists, the frame is start + DATA_BITS + parity + stop, and `parity_err` is functional.
  - Undefined: the PARITY state and parity logic are removed, the frame is start + DATA_BITS + stop, `parity_err` is tied to 0, and `PARITY_ODD` is ignored.

## Test plan
Bench uses CLKS_PER_BIT=16, DATA_BITS=8.
- Send 0xA5 as 8N1 with `rx_ready`=1 → `rx_valid` pulses 1 clk, `rx_data`=0xA5, no errors.
- Drive `rxd` low for 5 clk in idle → returns to IDLE, `busy` drops, no `rx_valid`, no error pulse.
- Send 0x3C with the stop bit low, then hold the line low 40 clk → one `frame_err` pulse, state held in BREAK until high, `rx_valid` stays 0.
- With `rx_ready`=0, send 0x11 then 0x22 back-to-back → `rx_data`=0x11 held, one `overrun` pulse. Then raise `rx_ready` → `rx_valid` clears next cycle.
- With the macro defined and PARITY_ODD=0, send 0x07 with parity bit 0 → `parity_err` pulse, no `rx_valid`. Repeat with parity bit 1 → `rx_data`=0x07.
- Assert `n_rst` at data bit 4 of 0xFF, release, then send 0x5A → all outputs reset immediately, and the next frame yields 0x5A cleanly.
